// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : state encoding and frame constants shared by UART rx/tx (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync : 2-flop synchronizer for the idle-high rx line (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver : 8N1 serial receiver with mid-bit sampling (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = FRAME_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 read_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 byte_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .sync_out (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      byte_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= 1'b0;

      // Host handshake; a good stop below overrides byte_ready on the same edge.
      if (read_ack && byte_ready) begin
        byte_ready <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s == START_LEVEL) begin
            state    <= START;
            baud_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rx_s == START_LEVEL) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            if (rx_s == STOP_LEVEL) begin
              rx_data    <= shift_reg;
              byte_ready <= 1'b1;
              // A same-cycle ack retires the old byte, so it is not an overrun.
              if (byte_ready && !read_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver : directed table plus randomized frames for uart_receiver
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

  localparam int BIT_CYC   = 16;
  localparam int DONE_EDGE = 154;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       read_ack = 1'b0;
  logic [7:0] rx_data;
  logic       byte_ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_receiver #(.BAUD_DIV(16), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .read_ack      (read_ack),
    .rx_data       (rx_data),
    .byte_ready    (byte_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         ack_done;
    bit         ack_after;
    logic [7:0] exp_data;
    logic       exp_ready;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    read_ack = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return stop;
  endfunction

  // Drives one full frame; j counts edges from E0 (the edge that captures the start bit).
  task automatic run_frame(input vec_t v);
    for (int j = 0; j < 10 * BIT_CYC; j++) begin
      rx = frame_bit(v.data, v.stop, j / BIT_CYC);
      read_ack = (v.ack_done && j == DONE_EDGE);
      step();
      if (j == 1) check("busy_before_E2", busy, 0);
      if (j == 2) check("busy_at_E2", busy, 1);
      if (j == DONE_EDGE - 1) begin
        check("busy_before_done", busy, 1);
        check("fe_before_done", framing_error, 0);
      end
      if (j == DONE_EDGE) begin
        check("rx_data", rx_data, v.exp_data);
        check("byte_ready", byte_ready, v.exp_ready);
        check("framing_error", framing_error, v.exp_fe);
        check("overrun", overrun, v.exp_ovr);
        check("busy_at_done", busy, 0);
      end
      if (j == DONE_EDGE + 1) check("fe_one_cycle", framing_error, 0);
    end
    read_ack = 1'b0;
    idle(24);
    if (v.ack_after) begin
      read_ack = 1'b1;
      step();
      read_ack = 1'b0;
      check("ack_clears_ready", byte_ready, 0);
      check("ack_clears_overrun", overrun, 0);
      check("ack_keeps_data", rx_data, v.exp_data);
    end
  endtask

  // Randomized run: line bits, ack pulses and completion events per edge.
  bit         line_q[$];
  bit         ack_q[$];
  bit         ev_v    [4096];
  bit         ev_good [4096];
  logic [7:0] ev_byte [4096];
  logic [7:0] m_data;
  logic       m_ready, m_ovr, m_fe;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h33, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h44, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1};

    // Reset state
    rst = 1'b0;
    rx = 1'b1;
    step();
    step();
    check("rst_rx_data", rx_data, 0);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_framing_error", framing_error, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    idle(4);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Three-cycle low glitch while idle: false start, no output.
    rx = 1'b0;
    for (int g = 0; g <= 12; g++) begin
      rx = (g < 3) ? 1'b0 : 1'b1;
      step();
      if (g == 2) check("glitch_busy_high", busy, 1);
      if (framing_error) check("glitch_no_fe", framing_error, 0);
      if (g == 12) begin
        check("glitch_busy_low", busy, 0);
        check("glitch_ready_low", byte_ready, 0);
        check("glitch_fe_low", framing_error, 0);
      end
    end
    idle(8);

    // Reset in the middle of data bit 4 after a byte is pending.
    run_frame('{8'h77, 1'b1, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0});
    for (int j = 0; j <= 5 * BIT_CYC + 8; j++) begin
      rx = frame_bit(8'h99, 1'b1, j / BIT_CYC);
      if (j == 5 * BIT_CYC + 8) begin
        check("busy_before_abort", busy, 1);
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b1;
    check("abort_rx_data", rx_data, 0);
    check("abort_byte_ready", byte_ready, 0);
    check("abort_framing_error", framing_error, 0);
    check("abort_overrun", overrun, 0);
    check("abort_busy", busy, 0);
    idle(20);
    run_frame('{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0});

    // Randomized frames against a transaction-timing reference model.
    rst = 1'b0;
    rx = 1'b1;
    step();
    step();
    rst = 1'b1;
    m_data = 8'h00;
    m_ready = 1'b0;
    m_ovr = 1'b0;
    for (int k = 0; k < 4; k++) line_q.push_back(1'b1);
    for (int f = 0; f < 12; f++) begin
      int         s;
      logic [7:0] b;
      bit         good;
      int         gap;
      s = line_q.size();
      b = 8'($urandom);
      good = ($urandom_range(3) != 0);
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < BIT_CYC; c++)
          line_q.push_back(frame_bit(b, good, k));
      ev_v[s + DONE_EDGE] = 1'b1;
      ev_good[s + DONE_EDGE] = good;
      ev_byte[s + DONE_EDGE] = b;
      gap = good ? int'($urandom_range(20)) : 24 + int'($urandom_range(8));
      for (int k = 0; k < gap; k++) line_q.push_back(1'b1);
    end
    for (int k = 0; k < 30; k++) line_q.push_back(1'b1);
    for (int k = 0; k < line_q.size(); k++) ack_q.push_back($urandom_range(5) == 0);

    for (int i = 0; i < line_q.size(); i++) begin
      rx = line_q[i];
      read_ack = ack_q[i];
      step();
      m_fe = 1'b0;
      if (ev_v[i] && ev_good[i]) begin
        if (m_ready && !ack_q[i]) m_ovr = 1'b1;
        else if (m_ready && ack_q[i]) m_ovr = 1'b0;
        m_data = ev_byte[i];
        m_ready = 1'b1;
      end else begin
        if (ev_v[i]) m_fe = 1'b1;
        if (ack_q[i] && m_ready) begin
          m_ready = 1'b0;
          m_ovr = 1'b0;
        end
      end
      check("random_outputs", {rx_data, byte_ready, framing_error, overrun},
            {m_data, m_ready, m_fe, m_ovr});
    end
    read_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
